paj_cfg_seq: RTL and testbench
==============================

PAJ_CFG_SEQ -- requirements
Module: paj_cfg_seq

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h73, is the 7-bit sensor device ID.
REQ-002 Parameter CFG_LEN, default 8'd32, is the number of configuration ROM entries (1..255).
REQ-003 Parameter WAKE_CYC, default 50_000, is the post-wake wait in sys_clk cycles (1 ms at 50 MHz).
REQ-004 Parameter POLL_CYC, default 2_500_000, is the gesture poll period in sys_clk cycles.
REQ-005 sys_clk  in  1  system clock; one clock domain.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins wake+configuration.
REQ-008 i2c_req  out  1  command request to the byte-level I2C master.
REQ-009 i2c_wr  out  1  1 = register write, 0 = register read.
REQ-010 i2c_dev  out  7  device address, always SLAVE_ADDR.
REQ-011 i2c_reg  out  8  register address.
REQ-012 i2c_wdata  out  8  write data.
REQ-013 i2c_ack  in  1  master accepted the command (one-cycle pulse).
REQ-014 i2c_done  in  1  transaction finished (one-cycle pulse).
REQ-015 i2c_nack  in  1  slave NACK, valid together with i2c_done.
REQ-016 i2c_rdata  in  8  read data, valid together with i2c_done.
REQ-017 cfg_done  out  1  level; configuration complete.
REQ-018 gesture  out  8  last nonzero gesture flag byte.
REQ-019 gesture_vld  out  1  one-cycle pulse when gesture updates.
REQ-020 err  out  1  sticky error level.

Function
REQ-021 States: IDLE, WAKE, WAKE_WAIT, CFG, CFG_WAIT, POLL_WAIT, RD_GES, RD_WAIT, ERR.
REQ-022 IDLE -> WAKE on start; start is ignored in every other state.
REQ-023 WAKE: write reg 8'hEF data 8'h00; i2c_done returns WAKE_WAIT with NACK ignored (sensor is asleep).
REQ-024 WAKE_WAIT: count WAKE_CYC cycles, then CFG with ROM index 0.
REQ-025 CFG: issue write of ROM {reg,data} at current index; CFG_WAIT until i2c_done.
REQ-026 CFG_WAIT, done without NACK: index increments; index == CFG_LEN-1 completes -> cfg_done=1, POLL_WAIT; otherwise CFG.
REQ-027 POLL_WAIT: count POLL_CYC cycles, then RD_GES; RD_GES issues read of reg 8'h43, then RD_WAIT.
REQ-028 RD_WAIT, done without NACK: if i2c_rdata != 0, load gesture and pulse gesture_vld the next cycle; zero data leaves gesture unchanged; return POLL_WAIT.
REQ-029 Request handshake: i2c_req rises on state entry and holds, with i2c_wr/reg/wdata stable, until the cycle i2c_ack is sampled high; it is then low until the next command.
REQ-030 i2c_done arriving in the same cycle as i2c_ack is accepted; i2c_done or i2c_ack seen in a state not awaiting it is ignored.
REQ-031 NACK in CFG_WAIT or RD_WAIT -> ERR (subject to REQ-036); ERR sets err=1, clears cfg_done, and is left only by reset.
REQ-032 Wait counters are sized to ceil(log2(max param)) bits and compare against param-1; no wrap-around inside a state.

Reset
REQ-033 Asynchronous assertion of sys_rst_n forces IDLE, i2c_req=0, i2c_wr=0, i2c_reg=0, i2c_wdata=0, cfg_done=0, gesture=0, gesture_vld=0, err=0, and clears counters and ROM index, including mid-transaction.
REQ-034 After deassertion, no command is issued until start.

Configuration
REQ-035 Macro PAJ_RETRY_EN selects NACK-retry support.
REQ-036 With PAJ_RETRY_EN: a NACK in CFG_WAIT or RD_WAIT reissues the same command up to 3 times (4 attempts total); the retry counter clears on each success; ERR only after the 4th NACK. Without it: first NACK -> ERR.

Structure
REQ-037 Shared package paj_pkg holds the state encoding, register constants 8'hEF, 8'h43, and the retry limit 3.
REQ-038 Sub-module paj_cfg_rom: combinational index[7:0] -> {reg[7:0], data[7:0]} table, CFG_LEN entries.

Verification
REQ-039 start, master model acks after 2 cycles and returns NACK on wake -> wake ignored, CFG_LEN writes in ROM order, cfg_done=1.
REQ-040 Poll returns rdata 8'h04 -> gesture=8'h04, one gesture_vld pulse; next poll returns 8'h00 -> gesture stays 8'h04, no pulse.
REQ-041 NACK on CFG index 5 without macro -> err=1, cfg_done=0, i2c_req stays 0.
REQ-042 With PAJ_RETRY_EN: NACK 3 times then ACK at index 5 -> sequence completes, err=0; NACK 4 times -> err=1.
REQ-043 sys_rst_n low while CFG_WAIT at index 10 -> all outputs at reset values; after new start, sequence restarts at WAKE.
REQ-044 i2c_ack and i2c_done in the same cycle, plus a spurious i2c_done in POLL_WAIT -> single advance, spurious done ignored.

Source files
------------

// File: rtl/paj_pkg.sv
// Shared definitions for the PAJ gesture-sensor configuration sequencer:
// FSM encoding, sensor register constants, retry limit and command types.
package paj_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAKE      = 4'd1;
  localparam logic [3:0] ST_WAKE_WAIT = 4'd2;
  localparam logic [3:0] ST_CFG       = 4'd3;
  localparam logic [3:0] ST_CFG_WAIT  = 4'd4;
  localparam logic [3:0] ST_POLL_WAIT = 4'd5;
  localparam logic [3:0] ST_RD_GES    = 4'd6;
  localparam logic [3:0] ST_RD_WAIT   = 4'd7;
  localparam logic [3:0] ST_ERR       = 4'd8;

  localparam logic [7:0] REG_BANK_SEL = 8'hEF;
  localparam logic [7:0] REG_GES_FLAG = 8'h43;
  localparam logic [1:0] RETRY_MAX    = 2'd3;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_ent_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } i2c_cmd_t;

  localparam i2c_cmd_t WAKE_CMD = '{wr: 1'b1, addr: REG_BANK_SEL, data: 8'h00};
  localparam i2c_cmd_t RD_CMD   = '{wr: 1'b0, addr: REG_GES_FLAG, data: 8'h00};

  function automatic i2c_cmd_t mk_wr(input cfg_ent_t e);
    return '{wr: 1'b1, addr: e.addr, data: e.data};
  endfunction

endpackage

// File: rtl/paj_cfg_rom.sv
// Configuration ROM: register/value pairs written to the sensor after wake-up.
// Indices at or beyond CFG_LEN read as zero.
module paj_cfg_rom
  import paj_pkg::*;
#(
  parameter logic [7:0] CFG_LEN = 8'd32
) (
  input  logic [7:0] index,
  output cfg_ent_t   ent
);

  always_comb begin
    ent = '0;
    if (index < CFG_LEN) begin
      case (index)
        8'd0:    ent = 16'h3229;
        8'd1:    ent = 16'h3301;
        8'd2:    ent = 16'h3400;
        8'd3:    ent = 16'h3501;
        8'd4:    ent = 16'h3600;
        8'd5:    ent = 16'h3707;
        8'd6:    ent = 16'h3817;
        8'd7:    ent = 16'h3906;
        8'd8:    ent = 16'h3A12;
        8'd9:    ent = 16'h3F00;
        8'd10:   ent = 16'h4002;
        8'd11:   ent = 16'h41FF;
        8'd12:   ent = 16'h4201;
        8'd13:   ent = 16'h462D;
        8'd14:   ent = 16'h470F;
        8'd15:   ent = 16'h483C;
        8'd16:   ent = 16'h4900;
        8'd17:   ent = 16'h4A1E;
        8'd18:   ent = 16'h4B00;
        8'd19:   ent = 16'h4C20;
        8'd20:   ent = 16'h4D00;
        8'd21:   ent = 16'h4E1A;
        8'd22:   ent = 16'h4F14;
        8'd23:   ent = 16'h5000;
        8'd24:   ent = 16'h5110;
        8'd25:   ent = 16'h5200;
        8'd26:   ent = 16'h5C02;
        8'd27:   ent = 16'h5D00;
        8'd28:   ent = 16'h5E10;
        8'd29:   ent = 16'h5F3F;
        8'd30:   ent = 16'h6027;
        8'd31:   ent = 16'h6128;
        default: ent = '0;
      endcase
    end
  end

endmodule

// File: rtl/paj_cfg_seq.sv
// PAJ gesture sensor sequencer: wake, ROM-driven configuration, then periodic
// gesture-flag polling over a byte-level I2C master. PAJ_RETRY_EN enables NACK retry.
module paj_cfg_seq
  import paj_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h73,
  parameter logic [7:0] CFG_LEN    = 8'd32,
  parameter int         WAKE_CYC   = 50_000,
  parameter int         POLL_CYC   = 2_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  output logic       i2c_req,
  output logic       i2c_wr,
  output logic [6:0] i2c_dev,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_ack,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  input  logic [7:0] i2c_rdata,
  output logic       cfg_done,
  output logic [7:0] gesture,
  output logic       gesture_vld,
  output logic       err
);

`ifdef PAJ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int CNT_MAX = (WAKE_CYC > POLL_CYC) ? WAKE_CYC : POLL_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYC - 1);
  localparam logic [7:0]       CFG_LAST  = CFG_LEN - 8'd1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [1:0]       retry_q, retry_d;
  logic             req_q, req_d;
  i2c_cmd_t         cmd_q, cmd_d;
  logic             cfg_done_q, cfg_done_d;
  logic [7:0]       gesture_q, gesture_d;
  logic             gvld_q, gvld_d;
  logic             err_q, err_d;

  logic [7:0] rom_idx;
  cfg_ent_t   rom_ent;
  logic       cmd_fin;

  // ROM is addressed by the index the next issued write will use: 0 out of the
  // wake wait, the same index on a retry, otherwise the following entry.
  assign rom_idx = (state_q == ST_WAKE_WAIT) ? 8'd0 :
                   (i2c_nack ? idx_q : idx_q + 8'd1);

  paj_cfg_rom #(.CFG_LEN(CFG_LEN)) u_rom (
    .index (rom_idx),
    .ent   (rom_ent)
  );

  // Completion only counts once the command has been accepted (or in that cycle).
  assign cmd_fin = i2c_done & (~req_q | i2c_ack);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    req_d      = req_q & ~i2c_ack;
    cmd_d      = cmd_q;
    cfg_done_d = cfg_done_q;
    gesture_d  = gesture_q;
    gvld_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WAKE; req_d = 1'b1; cmd_d = WAKE_CMD;
      end
      // Sensor is asleep during the wake write, so its NACK is expected.
      ST_WAKE: if (cmd_fin) begin
        state_d = ST_WAKE_WAIT; cnt_d = '0;
      end
      ST_WAKE_WAIT: begin
        if (cnt_q == WAKE_LAST) begin
          cnt_d = '0; idx_d = '0; retry_d = '0;
          state_d = ST_CFG; req_d = 1'b1; cmd_d = mk_wr(rom_ent);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CFG, ST_CFG_WAIT: begin
        if (cmd_fin && !i2c_nack) begin
          retry_d = '0;
          if (idx_q == CFG_LAST) begin
            cfg_done_d = 1'b1; state_d = ST_POLL_WAIT; cnt_d = '0;
          end else begin
            idx_d = idx_q + 8'd1;
            state_d = ST_CFG; req_d = 1'b1; cmd_d = mk_wr(rom_ent);
          end
        end else if (cmd_fin && RETRY_EN && retry_q != RETRY_MAX) begin
          retry_d = retry_q + 2'd1;
          state_d = ST_CFG; req_d = 1'b1; cmd_d = mk_wr(rom_ent);
        end else if (cmd_fin) begin
          state_d = ST_ERR; err_d = 1'b1; cfg_done_d = 1'b0; req_d = 1'b0;
        end else if (state_q == ST_CFG) begin
          state_d = ST_CFG_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        if (cnt_q == POLL_LAST) begin
          cnt_d = '0; state_d = ST_RD_GES; req_d = 1'b1; cmd_d = RD_CMD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_GES, ST_RD_WAIT: begin
        if (cmd_fin && !i2c_nack) begin
          retry_d = '0;
          if (i2c_rdata != 8'h00) begin
            gesture_d = i2c_rdata; gvld_d = 1'b1;
          end
          state_d = ST_POLL_WAIT; cnt_d = '0;
        end else if (cmd_fin && RETRY_EN && retry_q != RETRY_MAX) begin
          retry_d = retry_q + 2'd1;
          state_d = ST_RD_GES; req_d = 1'b1; cmd_d = RD_CMD;
        end else if (cmd_fin) begin
          state_d = ST_ERR; err_d = 1'b1; cfg_done_d = 1'b0; req_d = 1'b0;
        end else if (state_q == ST_RD_GES) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_ERR: begin
        err_d = 1'b1; cfg_done_d = 1'b0; req_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      req_q      <= 1'b0;
      cmd_q      <= '0;
      cfg_done_q <= 1'b0;
      gesture_q  <= '0;
      gvld_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      cfg_done_q <= cfg_done_d;
      gesture_q  <= gesture_d;
      gvld_q     <= gvld_d;
      err_q      <= err_d;
    end
  end

  assign i2c_req     = req_q;
  assign i2c_wr      = cmd_q.wr;
  assign i2c_dev     = SLAVE_ADDR;
  assign i2c_reg     = cmd_q.addr;
  assign i2c_wdata   = cmd_q.data;
  assign cfg_done    = cfg_done_q;
  assign gesture     = gesture_q;
  assign gesture_vld = gvld_q;
  assign err         = err_q;

endmodule

// File: tb/tb_paj_cfg_seq.sv
// Directed bench for paj_cfg_seq with a behavioural I2C master that logs commands.
module tb_paj_cfg_seq;

  localparam int         WAKE = 20;
  localparam int         POLL = 40;
  localparam int         LEN  = 32;
  localparam logic [7:0] NACK_REG = 8'h37;  // ROM index 5
  localparam logic [16:0] WAKE_C = {1'b1, 8'hEF, 8'h00};

  logic       sys_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0;
  logic       i2c_req, i2c_wr;
  logic [6:0] i2c_dev;
  logic [7:0] i2c_reg, i2c_wdata;
  logic       i2c_ack, i2c_done, i2c_nack;
  logic [7:0] i2c_rdata;
  logic       cfg_done, gesture_vld, err;
  logic [7:0] gesture;

  int n_checks = 0, n_errs = 0;
  logic [16:0] cmd_log[$];
  int gv_cnt = 0;
  int m_epoch = 0, m_cfg_nacks = 0, m_spur = 0;
  bit m_same = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  logic [15:0] rom_tab [LEN] = '{
    16'h3229, 16'h3301, 16'h3400, 16'h3501, 16'h3600, 16'h3707, 16'h3817, 16'h3906,
    16'h3A12, 16'h3F00, 16'h4002, 16'h41FF, 16'h4201, 16'h462D, 16'h470F, 16'h483C,
    16'h4900, 16'h4A1E, 16'h4B00, 16'h4C20, 16'h4D00, 16'h4E1A, 16'h4F14, 16'h5000,
    16'h5110, 16'h5200, 16'h5C02, 16'h5D00, 16'h5E10, 16'h5F3F, 16'h6027, 16'h6128};

  paj_cfg_seq #(.CFG_LEN(8'd32), .WAKE_CYC(WAKE), .POLL_CYC(POLL)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg),
    .i2c_wdata(i2c_wdata), .i2c_ack(i2c_ack), .i2c_done(i2c_done),
    .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata), .cfg_done(cfg_done),
    .gesture(gesture), .gesture_vld(gesture_vld), .err(err));

  always #5 sys_clk = ~sys_clk;

  // Master: ack on the second cycle req is seen, done one cycle later (or with ack).
  initial begin : master
    int last_epoch, last_spur, given;
    logic [16:0] cmd;
    bit nk;
    last_epoch = 0; last_spur = 0; given = 0;
    i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(negedge sys_clk);
      i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
      if (m_epoch != last_epoch) begin last_epoch = m_epoch; given = 0; end
      if (m_spur != last_spur) begin
        last_spur = m_spur; i2c_done = 1'b1; i2c_rdata = m_rdata;
      end else if (sys_rst_n && i2c_req) begin
        cmd = {i2c_wr, i2c_reg, i2c_wdata};
        @(negedge sys_clk);
        cmd_log.push_back(cmd);
        nk = 1'b0;
        if (cmd[16] && cmd[15:8] == 8'hEF) nk = 1'b1;
        else if (cmd[16] && cmd[15:8] == NACK_REG && given < m_cfg_nacks) begin
          nk = 1'b1; given++;
        end
        i2c_ack = 1'b1;
        if (!m_same) begin @(negedge sys_clk); i2c_ack = 1'b0; end
        i2c_done = 1'b1; i2c_nack = nk; i2c_rdata = m_rdata;
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (gesture_vld === 1'b1) gv_cnt++;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk); sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  // kind 0: cfg_done, 1: err, 2: command log reaches arg entries
  task automatic wait_until(input int kind, input int arg, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if ((kind == 0 && cfg_done === 1'b1) || (kind == 1 && err === 1'b1) ||
          (kind == 2 && cmd_log.size() >= arg)) begin
        ok = 1'b1; break;
      end
    end
  endtask

  function automatic int first_bad(input int base);
    for (int i = 0; i < LEN; i++)
      if (cmd_log[base + 1 + i] !== {1'b1, rom_tab[i]}) return i;
    return -1;
  endfunction

  task automatic test_reset();
    bit seen;
    sys_rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if ({i2c_req, i2c_wr, i2c_reg, i2c_wdata, cfg_done, gesture, gesture_vld, err} !== 29'd0) begin
      n_errs++;
      $display("FAIL rst_outputs got req=%b wr=%b reg=%h wd=%h done=%b ges=%h gv=%b err=%b exp all 0",
               i2c_req, i2c_wr, i2c_reg, i2c_wdata, cfg_done, gesture, gesture_vld, err);
    end
    n_checks++;
    if (i2c_dev !== 7'h73) begin n_errs++; $display("FAIL rst_dev got %h exp 73", i2c_dev); end
    sys_rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge sys_clk); if (i2c_req !== 1'b0) seen = 1'b1; end
    n_checks++;
    if (seen) begin n_errs++; $display("FAIL idle_no_req got req seen exp none"); end
  endtask

  task automatic test_config();
    int base, bad;
    bit ok;
    base = cmd_log.size();
    pulse_start();
    wait_until(0, 0, 3000, ok);
    n_checks++;
    if (!ok) begin n_errs++; $display("FAIL cfg_timeout got cfg_done=%b exp 1", cfg_done); end
    n_checks++;
    if (cmd_log.size() - base != LEN + 1) begin
      n_errs++; $display("FAIL cfg_count got %0d exp %0d", cmd_log.size() - base, LEN + 1);
    end else begin
      n_checks++;
      if (cmd_log[base] !== WAKE_C) begin
        n_errs++; $display("FAIL wake_cmd got %h exp %h", cmd_log[base], WAKE_C);
      end
      bad = first_bad(base);
      n_checks++;
      if (bad != -1) begin n_errs++; $display("FAIL cfg_order got first bad index %0d exp -1", bad); end
    end
    n_checks++;
    if ({cfg_done, err} !== 2'b10) begin
      n_errs++; $display("FAIL cfg_flags got done=%b err=%b exp 1 0", cfg_done, err);
    end
  endtask

  task automatic test_gesture();
    int base, g0;
    bit ok, wr_seen;
    m_rdata = 8'h04; base = cmd_log.size(); g0 = gv_cnt;
    wait_until(2, base + 1, 500, ok);
    n_checks++;
    if (!ok || cmd_log[base][16:8] !== 9'h043) begin
      n_errs++; $display("FAIL poll_read got ok=%b exp read of 43", ok);
    end
    repeat (6) @(negedge sys_clk);
    n_checks++;
    if (gesture !== 8'h04) begin n_errs++; $display("FAIL ges_load got %h exp 04", gesture); end
    n_checks++;
    if (gv_cnt - g0 != 1) begin n_errs++; $display("FAIL ges_pulse got %0d exp 1", gv_cnt - g0); end
    m_rdata = 8'h00;
    wait_until(2, base + 2, 500, ok);
    repeat (6) @(negedge sys_clk);
    n_checks++;
    if (!ok || gesture !== 8'h04 || gv_cnt - g0 != 1) begin
      n_errs++;
      $display("FAIL ges_zero got ok=%b ges=%h pulses=%0d exp 1 04 1", ok, gesture, gv_cnt - g0);
    end
    // start outside IDLE must not restart configuration
    base = cmd_log.size();
    pulse_start();
    repeat (60) @(negedge sys_clk);
    wr_seen = 1'b0;
    for (int i = base; i < cmd_log.size(); i++) if (cmd_log[i][16]) wr_seen = 1'b1;
    n_checks++;
    if (wr_seen || cfg_done !== 1'b1) begin
      n_errs++; $display("FAIL start_ignored got wr=%b done=%b exp 0 1", wr_seen, cfg_done);
    end
  endtask

  task automatic test_reset_mid();
    int base, bad;
    bit ok;
    do_reset();
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(posedge sys_clk); #1;
      if (i2c_req === 1'b1 && i2c_reg === 8'h40) ok = 1'b1;
    end
    for (int k = 0; k < 20 && ok; k++) begin
      @(posedge sys_clk); #1;
      if (i2c_req === 1'b0) break;
    end
    n_checks++;
    if (!ok || i2c_req !== 1'b0) begin n_errs++; $display("FAIL mid_reach got ok=%b exp 1", ok); end
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({i2c_req, i2c_wr, i2c_reg, i2c_wdata, cfg_done, gesture, gesture_vld, err} !== 29'd0) begin
      n_errs++;
      $display("FAIL mid_rst got req=%b wr=%b reg=%h wd=%h done=%b err=%b exp all 0",
               i2c_req, i2c_wr, i2c_reg, i2c_wdata, cfg_done, err);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    n_checks++;
    if ({i2c_req, cfg_done} !== 2'b00) begin
      n_errs++; $display("FAIL mid_idle got req=%b done=%b exp 0 0", i2c_req, cfg_done);
    end
    base = cmd_log.size();
    pulse_start();
    wait_until(0, 0, 3000, ok);
    n_checks++;
    if (!ok || cmd_log.size() - base != LEN + 1 || cmd_log[base] !== WAKE_C) begin
      n_errs++; $display("FAIL mid_restart got ok=%b cnt=%0d exp 1 %0d", ok, cmd_log.size() - base, LEN + 1);
    end else begin
      bad = first_bad(base);
      n_checks++;
      if (bad != -1) begin n_errs++; $display("FAIL mid_order got %0d exp -1", bad); end
    end
  endtask

  task automatic test_back_to_back();
    int base, g0, bad;
    bit ok;
    do_reset();
    m_same = 1'b1; m_rdata = 8'h00;
    base = cmd_log.size();
    pulse_start();
    wait_until(0, 0, 3000, ok);
    n_checks++;
    if (!ok || cmd_log.size() - base != LEN + 1) begin
      n_errs++; $display("FAIL b2b_count got ok=%b cnt=%0d exp 1 %0d", ok, cmd_log.size() - base, LEN + 1);
    end else begin
      bad = first_bad(base);
      n_checks++;
      if (bad != -1) begin n_errs++; $display("FAIL b2b_order got %0d exp -1", bad); end
    end
    m_rdata = 8'h55; base = cmd_log.size(); g0 = gv_cnt;
    m_spur++;
    repeat (5) @(negedge sys_clk);
    n_checks++;
    if (cmd_log.size() != base || gesture !== 8'h00 || gv_cnt != g0) begin
      n_errs++;
      $display("FAIL spur_done got cmds=%0d ges=%h pulses=%0d exp 0 00 0",
               cmd_log.size() - base, gesture, gv_cnt - g0);
    end
    wait_until(2, base + 1, 500, ok);
    repeat (6) @(negedge sys_clk);
    n_checks++;
    if (!ok || gesture !== 8'h55 || gv_cnt - g0 != 1) begin
      n_errs++; $display("FAIL b2b_read got ok=%b ges=%h pulses=%0d exp 1 55 1", ok, gesture, gv_cnt - g0);
    end
    m_same = 1'b0; m_rdata = 8'h00;
  endtask

`ifdef PAJ_RETRY_EN
  task automatic test_retry();
    int base;
    bit ok;
    do_reset();
    m_epoch++; m_cfg_nacks = 3; base = cmd_log.size();
    pulse_start();
    wait_until(0, 0, 3000, ok);
    n_checks++;
    if (!ok || err !== 1'b0 || cmd_log.size() - base != LEN + 4) begin
      n_errs++;
      $display("FAIL retry3 got ok=%b err=%b cnt=%0d exp 1 0 %0d", ok, err, cmd_log.size() - base, LEN + 4);
    end
    do_reset();
    m_epoch++; m_cfg_nacks = 4; base = cmd_log.size();
    pulse_start();
    wait_until(1, 0, 3000, ok);
    repeat (20) @(negedge sys_clk);
    n_checks++;
    if (!ok || {err, cfg_done, i2c_req} !== 3'b100 || cmd_log.size() - base != 10) begin
      n_errs++;
      $display("FAIL retry4 got err=%b done=%b req=%b cnt=%0d exp 1 0 0 10",
               err, cfg_done, i2c_req, cmd_log.size() - base);
    end
  endtask
`else
  task automatic test_nack();
    int base;
    bit ok, seen;
    do_reset();
    m_epoch++; m_cfg_nacks = 1; base = cmd_log.size();
    pulse_start();
    wait_until(1, 0, 3000, ok);
    n_checks++;
    if (!ok) begin n_errs++; $display("FAIL nack_timeout got err=%b exp 1", err); end
    seen = 1'b0;
    repeat (20) begin @(negedge sys_clk); if (i2c_req !== 1'b0) seen = 1'b1; end
    n_checks++;
    if ({err, cfg_done, seen} !== 3'b100) begin
      n_errs++; $display("FAIL nack_state got err=%b done=%b req_seen=%b exp 1 0 0", err, cfg_done, seen);
    end
    n_checks++;
    if (cmd_log.size() - base != 7) begin
      n_errs++; $display("FAIL nack_count got %0d exp 7", cmd_log.size() - base);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_config();
    test_gesture();
    test_reset_mid();
    test_back_to_back();
`ifdef PAJ_RETRY_EN
    test_retry();
`else
    test_nack();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
